spi_xfer_arbiter: RTL
=====================

# spi_xfer_arbiter

Controller that shares the single `shiftreg_out` SPI byte serializer between two requesters (0: host CPU port, 1: configuration/boot engine). It grants the serializer burst-wise in round-robin order, drives the active-low per-device chip selects, feeds bytes to the serializer's load interface and sequences on its `busy` flag. It sits between the requester logic and `shiftreg_out`, in the serializer's clock domain.

## Interface
Parameters:
- `CS_SETUP`, 2: cycles from `cs_n` falling to the first byte fetch; legal ≥1.
- `CS_GAP`, 2: cycles `cs_n` stays high after a burst before re-arbitration; legal ≥1.
- `BUSY_TIMEOUT`, 16: cycles allowed after a load for `sr_busy` to rise; legal ≥2.

Ports:
- `serial_clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `req0_valid`  in  1  requester 0 has a byte to send.
- `req0_data`  in  8  requester 0 byte.
- `req0_last`  in  1  this byte ends requester 0's burst.
- `req0_ready`  out  1  byte accepted this cycle when `req0_valid` is also high.
- `req1_valid`, `req1_data`, `req1_last`, `req1_ready`: same as requester 0.
- `grant`  out  2  one-hot current owner; `2'b00` when idle.
- `cs_n`  out  2  active-low chip select, bit N for requester N's device.
- `sr_data`  out  8  byte to the serializer's `data_in`.
- `sr_load_n`  out  1  to the serializer's `set_enable`; active-low load strobe.
- `sr_busy`  in  1  serializer's `busy`.
- `err`  out  1  one-cycle pulse on busy timeout.

## Operation
- Reset values: `grant`=00, `cs_n`=11, `sr_data`=00, `sr_load_n`=1, `req*_ready`=0, `err`=0. State IDLE; last-owner register = 1, so requester 0 wins the first tie.
- IDLE: if exactly one `reqN_valid` is high, grant N. If both are high, grant the requester that was not the last owner. Next state SETUP.
- SETUP: `cs_n[N]`=0 and `grant[N]`=1; hold `CS_SETUP` cycles, then FETCH.
- FETCH: `reqN_ready`=1 (combinational: state==FETCH and owner==N). When `reqN_valid` is high:
  - capture `reqN_data` into `sr_data` and `reqN_last` into the last flag;
  - next state LOAD.
  - If valid is low, stay in FETCH with `cs_n` held low indefinitely; the burst is not released.
- LOAD: `sr_load_n`=0 for exactly one cycle; then WAIT_BUSY.
- WAIT_BUSY: wait for `sr_busy`=1, then SHIFT. If `BUSY_TIMEOUT` cycles pass without it: pulse `err`, abort the burst, go to GAP.
- SHIFT: wait for `sr_busy`=0. Then GAP if the last flag is set, otherwise FETCH.
- GAP: `cs_n`=11, `grant`=00, last owner = N; hold `CS_GAP` cycles, then IDLE.
- The non-owner's `ready` is always 0. A non-owner's request never preempts a burst in progress.
- `sr_data` is stable from LOAD until the next FETCH capture.
- Counters are sized `$clog2(max param)+1`. Each counter clears on state entry.

## Timing
- `reqN_valid` rises at edge t while in IDLE: `cs_n[N]` low after t+1; first `ready` at t+1+`CS_SETUP`.
- Byte accepted at edge f: `sr_load_n` low during cycle f+1, high again at f+2.
- `sr_busy` falls at edge b: next `ready` at b+1 (non-last byte), or `cs_n` high at b+1 (last byte).
- Back-to-back bursts: the second burst's `cs_n` falls `CS_GAP`+1 cycles after the first burst's `cs_n` rises.
- `sr_busy` already high on LOAD exit is accepted immediately (SHIFT next cycle).
- `reset` low during any state: all outputs take their reset values at that edge, and a serializer shift still in flight is ignored. `req` inputs are ignored while `reset`=0.

## Test plan
- Single burst: req0 sends 8'hF1 with last=1; the serializer model raises busy 2 cycles after load for 16 cycles → `cs_n`=10, one `sr_load_n` pulse, `sr_data`=F1, `cs_n`=11 one cycle after busy falls, `grant` returns to 00.
- Multi-byte burst: req1 sends A5, 3C, 7E (last on 7E) → three load pulses, `cs_n[1]` continuously low, `req1_ready` accepted exactly 3 times.
- Contention: req0 and req1 both valid from reset, each a 1-byte burst → order is 0, 1, then 0 again when both re-request; `CS_GAP` high cycles between bursts.
- Stall: req0 sends a 2-byte burst and drops `valid` for 20 cycles between the bytes → `cs_n[0]` stays low, no load pulse during the stall, req1 is not granted.
- Timeout: `sr_busy` held at 0 after a load → `err` pulses once at `BUSY_TIMEOUT` cycles, `cs_n` returns to 11, the arbiter resumes with the next request.
- Reset mid-SHIFT: `reset`=0 for one cycle → next cycle shows `cs_n`=11, `sr_load_n`=1, `grant`=00; afterwards req0 wins a tie.

Source files
------------

// File: rtl/spi_xfer_arbiter.sv
// Burst-wise round-robin arbiter sharing one SPI byte serializer between two requesters.
// Drives per-device chip selects and the serializer load strobe, and sequences on its busy flag.
//   state     | meaning
//   IDLE      | no owner, cs_n high, arbitrating
//   SETUP     | cs_n low, waiting CS_SETUP cycles before first fetch
//   FETCH     | owner's ready high, waiting for a byte
//   LOAD      | byte captured, strobe sr_load_n next
//   WAIT_BUSY | waiting for serializer busy to rise (timeout -> err)
//   SHIFT     | serializer shifting, waiting for busy to fall
//   GAP       | cs_n high for CS_GAP cycles before re-arbitration
module spi_xfer_arbiter #(
  parameter int CS_SETUP     = 2,
  parameter int CS_GAP       = 2,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic       serial_clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic [1:0] grant,
  output logic [1:0] cs_n,
  output logic [7:0] sr_data,
  output logic       sr_load_n,
  input  logic       sr_busy,
  output logic       err
);

  localparam int MAX_SG = (CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP;
  localparam int MAX_P  = (MAX_SG > BUSY_TIMEOUT) ? MAX_SG : BUSY_TIMEOUT;
  localparam int CW     = $clog2(MAX_P) + 1;

  typedef enum logic [2:0] {IDLE, SETUP, FETCH, LOAD, WAIT_BUSY, SHIFT, GAP} state_t;

  state_t        state;
  logic          owner;
  logic          last_owner;
  logic          last_flag;
  logic [CW-1:0] cnt;
  logic          pick;
  logic          own_valid;
  logic          own_last;
  logic [7:0]    own_data;

  // On a tie the requester that did not own the previous burst wins.
  always_comb begin
    pick      = (req0_valid && req1_valid) ? ~last_owner : req1_valid;
    own_valid = owner ? req1_valid : req0_valid;
    own_last  = owner ? req1_last  : req0_last;
    own_data  = owner ? req1_data  : req0_data;
  end

  assign req0_ready = (state == FETCH) && !owner;
  assign req1_ready = (state == FETCH) &&  owner;

  always_ff @(posedge serial_clk) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      last_flag  <= 1'b0;
      cnt        <= '0;
      grant      <= 2'b00;
      cs_n       <= 2'b11;
      sr_data    <= 8'h00;
      sr_load_n  <= 1'b1;
      err        <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (req0_valid || req1_valid) begin
            owner <= pick;
            grant <= pick ? 2'b10 : 2'b01;
            cs_n  <= pick ? 2'b01 : 2'b10;
            cnt   <= CW'(CS_SETUP - 1);
            state <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == '0) state <= FETCH;
          else           cnt   <= cnt - 1'b1;
        end
        FETCH: begin
          if (own_valid) begin
            sr_data   <= own_data;
            last_flag <= own_last;
            state     <= LOAD;
          end
        end
        LOAD: begin
          sr_load_n <= 1'b0;
          cnt       <= CW'(BUSY_TIMEOUT - 1);
          state     <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          sr_load_n <= 1'b1;
          if (sr_busy) begin
            state <= SHIFT;
          end else if (cnt == '0) begin
            err        <= 1'b1;
            cs_n       <= 2'b11;
            grant      <= 2'b00;
            last_owner <= owner;
            cnt        <= CW'(CS_GAP - 1);
            state      <= GAP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        SHIFT: begin
          if (!sr_busy) begin
            if (last_flag) begin
              cs_n       <= 2'b11;
              grant      <= 2'b00;
              last_owner <= owner;
              cnt        <= CW'(CS_GAP - 1);
              state      <= GAP;
            end else begin
              state <= FETCH;
            end
          end
        end
        GAP: begin
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
